usb_rw_sched: RTL and testbench
===============================

USB_RW_SCHED -- requirements
Module: usb_rw_sched

Interface
REQ-001 Parameter MAX_RETRY, default 3, SHALL set the retries after a failed transaction; legal range 0..7.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_L  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Ports req0, req1  input  1 each  SHALL be the client requests: level, held until the matching done pulse.
REQ-005 Ports wr0, wr1  input  1 each  SHALL select the operation: 1 = write, 0 = read.
REQ-006 Ports page0, page1  input  16 each  SHALL carry the client memory page.
REQ-007 Ports wdata0, wdata1  input  64 each  SHALL carry the client write data.
REQ-008 Ports done0, done1  output  1 each  SHALL be the one-cycle completion pulses.
REQ-009 Port success  output  1  SHALL give the outcome, valid while any done pulse is high.
REQ-010 Port rdata  output  64  SHALL give the read data, valid with done when the read succeeded.
REQ-011 Ports start_read, start_write  output  1 each  SHALL drive the rw engine start inputs.
REQ-012 Ports RWmemPage  output  16 and RW_data_write  output  64  SHALL drive the engine operands.
REQ-013 Ports protocol_free, rwFSM_done, read_success, write_success  input  1 each  SHALL be the engine status inputs.
REQ-014 Port RW_data_read  input  64  SHALL be the engine read data.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, BUSY, RESP.
REQ-016 IDLE: when either request is high, the block SHALL grant one client, latch its wr, page and wdata into the operand registers, clear the retry count and go to ISSUE the next cycle.
REQ-017 Arbitration SHALL be round-robin. With both requests high, the client not granted last wins. After reset, client 0 has priority.
REQ-018 ISSUE: the block SHALL assert start_write (wr=1) or start_read (wr=0) from the latched wr bit. It SHALL go to BUSY in the first cycle protocol_free=1 and stay in ISSUE otherwise.
REQ-019 start_read and start_write SHALL never be asserted together, and SHALL be 0 outside ISSUE.
REQ-020 RWmemPage and RW_data_write SHALL come from the operand registers; client inputs SHALL NOT pass through combinationally.
REQ-021 BUSY: the block SHALL wait for rwFSM_done=1. The outcome SHALL be write_success for writes and read_success for reads.
REQ-022 On done with success=1, the block SHALL capture RW_data_read into rdata (reads only) and go to RESP.
REQ-023 On done with success=0: if retry count < MAX_RETRY, the block SHALL increment the count and return to ISSUE, keeping the operands. Otherwise it SHALL go to RESP with success=0.
REQ-024 RESP SHALL last exactly one cycle. It SHALL pulse done of the granted client, drive success, update the round-robin pointer and return to IDLE.
REQ-025 A new grant SHALL NOT occur in the RESP cycle. The minimum spacing between a done pulse and the next start is 2 cycles.
REQ-026 rdata SHALL hold its value until the next successful read. After a failed read it SHALL be unchanged.
REQ-027 A request that drops before its done pulse SHALL NOT abort the transaction in flight; done still pulses.
REQ-028 With MAX_RETRY=0, the first failure SHALL report success=0 immediately.

Reset
REQ-029 While rst_L=0: state=IDLE; all done outputs, success, start_read and start_write = 0; rdata=0; operand registers = 0; retry count = 0; round-robin pointer = client 0 priority.
REQ-030 Reset asserted mid-transaction SHALL abort it with no done pulse. The first grant after reset release SHALL follow REQ-016.

Structure
REQ-031 The state enum and request-slot types SHALL be defined in the shared USB package, next to the message-type constants.
REQ-032 Operand and rdata storage SHALL use the existing parameterised register module with ld, clr, rst_n and clk ports.
REQ-033 The round-robin selection SHALL be one sub-module, rr_arb2.

Verification
REQ-034 Client 0 read, page=16'h0012; engine done with read_success=1 and RW_data_read=64'hDEAD_BEEF_0000_0001 -> done0 pulses once, success=1, rdata=64'hDEAD_BEEF_0000_0001.
REQ-035 req0 and req1 rise in the same cycle, both writes -> client 0 is served first, then client 1; start_write is asserted twice with page0 and then page1 on RWmemPage.
REQ-036 Write where the engine fails 3 times and then succeeds, MAX_RETRY=3 -> 4 start_write issues and done with success=1.
REQ-037 Read that fails 4 times, MAX_RETRY=3 -> exactly 4 issues, done with success=0, rdata unchanged.
REQ-038 protocol_free held 0 for 10 cycles in ISSUE -> start stays asserted for all 10 cycles and BUSY is entered only in the cycle protocol_free=1.
REQ-039 rst_L driven low during BUSY -> all outputs are at reset values immediately, no done pulse, and the next request is served normally.

Source files
------------

// File: rtl/usb_rw_sched_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | usb_rw_sched_pkg                                                      |
// | Shared types for the USB read/write scheduler: the scheduler state    |
// | encoding and the request-slot record that holds a client operation.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package usb_rw_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  // One client operation as latched at grant time
  typedef struct packed {
    logic        wr;
    logic [15:0] page;
    logic [63:0] wdata;
  } req_slot_t;

  localparam int SLOT_W = $bits(req_slot_t);

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | rr_arb2                                                               |
// | Two-client round-robin selector. With both requests high the client   |
// | not served last wins; the pointer moves only when update is pulsed.   |
// | Ports: clk, rst_n (async, active-low), req[1:0], update, served       |
// |        (index of the client just completed), grant_valid, grant_idx   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Index of the client served last; resets to 1 so client 0 wins first.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= served;
    end
  end

  always_comb begin
    grant_valid = |req;
    if (req[0] && req[1]) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_reg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | usb_reg                                                               |
// | Parameterised load/clear register with asynchronous active-low reset. |
// | Ports: clk, rst_n (async, active-low), clr (sync clear, wins over ld),|
// |        ld (load d), d [WIDTH], q [WIDTH]                              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module usb_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_rw_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | usb_rw_sched                                                          |
// | Schedules read/write requests from two clients onto one rw engine,    |
// | with round-robin arbitration and up to MAX_RETRY retries per request. |
// | Ports: clk, rst_L (async, active-low)                                 |
// |   clients : req0/1, wr0/1, page0/1[16], wdata0/1[64] in;              |
// |             done0/1, success, rdata[64] out                           |
// |   engine  : start_read, start_write, RWmemPage[16], RW_data_write[64] |
// |             out; protocol_free, rwFSM_done, read_success,             |
// |             write_success, RW_data_read[64] in                        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module usb_rw_sched
  import usb_rw_sched_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] page0,
  input  logic [15:0] page1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        success,
  output logic [63:0] rdata,
  output logic        start_read,
  output logic        start_write,
  output logic [15:0] RWmemPage,
  output logic [63:0] RW_data_write,
  input  logic        protocol_free,
  input  logic        rwFSM_done,
  input  logic        read_success,
  input  logic        write_success,
  input  logic [63:0] RW_data_read
);

  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  sched_state_e state_q, state_d;
  req_slot_t    slot_d, op_q;
  logic         client_q;
  logic [2:0]   retry_q;
  logic         result_q;

  logic grant_valid, grant_idx;
  logic grant_take, busy_done, outcome, retry_take, rd_ld;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_L),
    .req         ({req1, req0}),
    .update      (state_q == RESP),
    .served      (client_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Operands of the granted client, frozen for the whole transaction
  assign slot_d.wr    = grant_idx ? wr1    : wr0;
  assign slot_d.page  = grant_idx ? page1  : page0;
  assign slot_d.wdata = grant_idx ? wdata1 : wdata0;

  assign grant_take = (state_q == IDLE) && grant_valid;
  assign busy_done  = (state_q == BUSY) && rwFSM_done;
  assign outcome    = op_q.wr ? write_success : read_success;
  assign retry_take = busy_done && !outcome && (retry_q < RETRY_LIMIT);
  assign rd_ld      = busy_done && outcome && !op_q.wr;

  usb_reg #(.WIDTH(SLOT_W)) u_op_reg (
    .clk   (clk),
    .rst_n (rst_L),
    .clr   (1'b0),
    .ld    (grant_take),
    .d     (slot_d),
    .q     (op_q)
  );

  usb_reg #(.WIDTH(64)) u_rdata_reg (
    .clk   (clk),
    .rst_n (rst_L),
    .clr   (1'b0),
    .ld    (rd_ld),
    .d     (RW_data_read),
    .q     (rdata)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= IDLE;
      client_q <= 1'b0;
      retry_q  <= '0;
      result_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        client_q <= grant_idx;
        retry_q  <= '0;
      end
      if (retry_take) begin
        retry_q <= retry_q + 3'd1;
      end
      if (busy_done) begin
        result_q <= outcome;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    start_read  = 1'b0;
    start_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        start_write = op_q.wr;
        start_read  = ~op_q.wr;
        if (protocol_free) state_d = BUSY;
      end
      BUSY: begin
        if (rwFSM_done) begin
          state_d = retry_take ? ISSUE : RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done0         = (state_q == RESP) && !client_q;
  assign done1         = (state_q == RESP) && client_q;
  assign success       = (state_q == RESP) && result_q;
  assign RWmemPage     = op_q.page;
  assign RW_data_write = op_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_usb_rw_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_usb_rw_sched                                                       |
// | Self-checking bench: behavioural rw engine, completion scoreboard,    |
// | table of single transactions plus arbitration/stall/reset sequences.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_usb_rw_sched;

  localparam int MAX_RETRY = 3;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [15:0] page0 = '0, page1 = '0;
  logic [63:0] wdata0 = '0, wdata1 = '0;
  logic        done0, done1, success, start_read, start_write;
  logic [63:0] rdata, RW_data_write;
  logic [15:0] RWmemPage;
  logic        protocol_free = 1'b1, rwFSM_done = 1'b0;
  logic        read_success = 1'b0, write_success = 1'b0;
  logic [63:0] RW_data_read = '0;

  always #5 clk = ~clk;

  usb_rw_sched #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk           (clk),
    .rst_L         (rst_L),
    .req0          (req0),
    .req1          (req1),
    .wr0           (wr0),
    .wr1           (wr1),
    .page0         (page0),
    .page1         (page1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .done0         (done0),
    .done1         (done1),
    .success       (success),
    .rdata         (rdata),
    .start_read    (start_read),
    .start_write   (start_write),
    .RWmemPage     (RWmemPage),
    .RW_data_write (RW_data_write),
    .protocol_free (protocol_free),
    .rwFSM_done    (rwFSM_done),
    .read_success  (read_success),
    .write_success (write_success),
    .RW_data_read  (RW_data_read)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        client;
    logic        success;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model_rdata = '0;
  int          done_seen = 0;
  logic        prev_done = 1'b0;

  task automatic push_exp(input logic c, input logic w, input int fails, input logic [63:0] rd);
    exp_t e;
    e.client  = c;
    e.success = (fails <= MAX_RETRY);
    if (!w && e.success) model_rdata = rd;
    e.rdata   = model_rdata;
    sb.push_back(e);
  endtask

  // Completion monitor: compares each done pulse against the queue head
  initial forever begin
    @(negedge clk);
    if (!rst_L) begin
      prev_done = 1'b0;
    end else begin
      if (done0 || done1) begin
        chk("done_onehot", {63'd0, done0 & done1}, 64'd0);
        chk("done_width", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done0:%0b,done1:%0b required=no_pulse", done0, done1);
        end else begin
          mon_e = sb.pop_front();
          chk("done_client", {63'd0, done1}, {63'd0, mon_e.client});
          chk("success", {63'd0, success}, {63'd0, mon_e.success});
          chk("rdata", rdata, mon_e.rdata);
        end
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
        done_seen++;
      end
      prev_done = done0 | done1;
    end
  end

  // ---------------- behavioural rw engine ----------------
  int          fail_left = 0;
  logic [63:0] rd_val = '0;
  int          pf_zero = 0;
  int          eng_cnt = 0;
  logic        eng_wr = 1'b0;
  int          issues = 0;
  int          held = 0;
  logic [15:0] page_log[$];
  logic [63:0] wdata_log[$];
  logic        kind_log[$];

  initial forever begin
    @(negedge clk);
    rwFSM_done    = 1'b0;
    read_success  = 1'b0;
    write_success = 1'b0;
    RW_data_read  = 64'hBAD0_BAD0_BAD0_BAD0;
    if (!rst_L) begin
      eng_cnt       = 0;
      protocol_free = 1'b1;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          rwFSM_done = 1'b1;
          if (fail_left > 0) begin
            fail_left--;
            write_success = ~eng_wr;
            read_success  = eng_wr;
          end else begin
            write_success = eng_wr;
            read_success  = ~eng_wr;
            RW_data_read  = rd_val;
          end
        end
      end
      if (start_read || start_write) begin
        chk("start_excl", {63'd0, start_read & start_write}, 64'd0);
        if (pf_zero > 0) begin
          protocol_free = 1'b0;
          pf_zero--;
          held++;
        end else begin
          protocol_free = 1'b1;
          issues++;
          page_log.push_back(RWmemPage);
          wdata_log.push_back(RW_data_write);
          kind_log.push_back(start_write);
          eng_wr  = start_write;
          eng_cnt = 2;
        end
      end else begin
        protocol_free = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic c, input logic w, input logic [15:0] p, input logic [63:0] d);
    if (c) begin
      wr1 = w; page1 = p; wdata1 = d; req1 = 1'b1;
    end else begin
      wr0 = w; page0 = p; wdata0 = d; req0 = 1'b1;
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_seen < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (done_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, done_seen, target);
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    issues = 0;
    held   = 0;
    page_log.delete();
    wdata_log.delete();
    kind_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done0"}, {63'd0, done0}, 64'd0);
    chk({tag, "_done1"}, {63'd0, done1}, 64'd0);
    chk({tag, "_success"}, {63'd0, success}, 64'd0);
    chk({tag, "_start_read"}, {63'd0, start_read}, 64'd0);
    chk({tag, "_start_write"}, {63'd0, start_write}, 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_page"}, {48'd0, RWmemPage}, 64'd0);
    chk({tag, "_wdata"}, RW_data_write, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        client;
    logic        wr;
    logic [15:0] page;
    logic [63:0] wdata;
    int          fails;
    logic [63:0] rd;
    int          exp_issues;
    logic        exp_success;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int tgt;

    vecs[0] = '{1'b0, 1'b0, 16'h0012, 64'h0, 0, 64'hDEAD_BEEF_0000_0001, 1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 16'hA5A5, 64'h1111_2222_3333_4444, 0, 64'h0, 1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 16'h0300, 64'h5555_6666_7777_8888, 3, 64'h0, 4, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h0401, 64'h0, 4, 64'hFFFF_0000_FFFF_0000, 4, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0502, 64'h0, 2, 64'h1234_5678_9ABC_DEF0, 3, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 64'h0, 0, 64'hCAFE_F00D_0BAD_BEEF, 1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous writes from both clients: client 0 first after reset
    clear_logs();
    fail_left = 0;
    push_exp(1'b0, 1'b1, 0, 64'h0);
    push_exp(1'b1, 1'b1, 0, 64'h0);
    tgt = done_seen + 2;
    drive_req(1'b0, 1'b1, 16'h0A0A, 64'hAAAA_0000_0000_0001);
    drive_req(1'b1, 1'b1, 16'h0B0B, 64'hBBBB_0000_0000_0002);
    wait_done(tgt, "dual_write");
    chk("dual_issues", issues, 2);
    if (page_log.size() == 2) begin
      chk("dual_page_first", {48'd0, page_log[0]}, 64'h0A0A);
      chk("dual_page_second", {48'd0, page_log[1]}, 64'h0B0B);
      chk("dual_wdata_first", wdata_log[0], 64'hAAAA_0000_0000_0001);
      chk("dual_kind_first", {63'd0, kind_log[0]}, 64'd1);
      chk("dual_kind_second", {63'd0, kind_log[1]}, 64'd1);
    end
    repeat (3) @(negedge clk);

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      fail_left = vecs[i].fails;
      rd_val    = vecs[i].rd;
      push_exp(vecs[i].client, vecs[i].wr, vecs[i].fails, vecs[i].rd);
      tgt = done_seen + 1;
      drive_req(vecs[i].client, vecs[i].wr, vecs[i].page, vecs[i].wdata);
      wait_done(tgt, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_issues", i), issues, vecs[i].exp_issues);
      if (page_log.size() > 0) begin
        chk($sformatf("vec%0d_page", i), {48'd0, page_log[0]}, {48'd0, vecs[i].page});
        chk($sformatf("vec%0d_kind", i), {63'd0, kind_log[0]}, {63'd0, vecs[i].wr});
        if (vecs[i].wr) chk($sformatf("vec%0d_wdata", i), wdata_log[0], vecs[i].wdata);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_rdata_hold", i), rdata, model_rdata);
    end

    // Engine busy: protocol_free held low for 10 cycles in ISSUE
    clear_logs();
    fail_left = 0;
    rd_val    = 64'h0F0F_0F0F_0F0F_0F0F;
    pf_zero   = 10;
    push_exp(1'b1, 1'b0, 0, rd_val);
    tgt = done_seen + 1;
    drive_req(1'b1, 1'b0, 16'h0777, 64'h0);
    wait_done(tgt, "stall");
    chk("stall_held", held, 10);
    chk("stall_issues", issues, 1);
    repeat (3) @(negedge clk);

    // Reset during BUSY aborts silently; pointer returns to client 0
    clear_logs();
    fail_left = 0;
    drive_req(1'b1, 1'b0, 16'h0888, 64'h0);
    for (int n = 0; n < 100 && eng_cnt == 0; n++) @(posedge clk);
    chk("abort_reached_busy", {63'd0, eng_cnt > 0}, 64'd1);
    @(negedge clk);
    rst_L = 1'b0;
    req1  = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_rdata = '0;
    repeat (5) @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    clear_logs();
    rd_val = 64'h0123_4567_89AB_CDEF;
    push_exp(1'b0, 1'b0, 0, rd_val);
    push_exp(1'b1, 1'b0, 0, rd_val);
    tgt = done_seen + 2;
    drive_req(1'b0, 1'b0, 16'h0C0C, 64'h0);
    drive_req(1'b1, 1'b0, 16'h0D0D, 64'h0);
    wait_done(tgt, "post_reset");
    chk("post_reset_issues", issues, 2);
    if (page_log.size() == 2) begin
      chk("post_reset_page_first", {48'd0, page_log[0]}, 64'h0C0C);
      chk("post_reset_page_second", {48'd0, page_log[1]}, 64'h0D0D);
    end
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
